stepper_step_gen: RTL
=====================

// Module: stepper_step_gen
// PURPOSE
//  Step/dir pulse generator for one stepper axis of the plotter SoC. Sits between
//  the core's motion-peripheral register interface and the io_m2 step/dir pins.
//  Accepts relative-move and homing commands over a valid/ready handshake.
//  Emits paced step pulses with direction setup time, tracks absolute position,
//  and honours the axis homing switch.
// PARAMETERS
//  STEP_W      16  width of cmd_steps and half_period
//  POS_W       32  width of signed absolute position counter
//  DIR_SETUP   16  cycles dir_o is held stable before the first step after a dir change
//  SYNC_STAGES  2  flop stages in the home_sw synchronizer (>=2)
// PORTS
//  clock        in   1       system clock
//  reset_n      in   1       asynchronous active-low reset
//  cmd_valid    in   1       command present
//  cmd_ready    out  1       block can accept a command (high only in IDLE)
//  cmd_steps    in   STEP_W  step count for a move (ignored when cmd_home=1)
//  cmd_dir      in   1       1 = positive (position increments), 0 = negative
//  cmd_home     in   1       1 = homing command: step negative until switch
//  half_period  in   STEP_W  step high and low time in cycles, latched on accept
//  abort        in   1       terminate the current command
//  home_sw      in   1       asynchronous homing switch, active high
//  step_o       out  1       step pulse to driver
//  dir_o        out  1       direction to driver
//  busy         out  1       command in progress (= !cmd_ready)
//  done         out  1       one-cycle pulse when a command completes or aborts
//  position     out  POS_W   signed absolute position in steps
//  homed        out  1       sticky; set when a switch hit zeroes position
// BEHAVIOUR
//  Reset: step_o=0, dir_o=0, busy=0, done=0, position=0, homed=0, cmd_ready=1, state IDLE.
//  States: IDLE, SETUP, HIGH, LOW, FINISH.
//  Accept: cmd_valid & cmd_ready in cycle N. Latch steps, half_period (0 treated as 1), home flag.
//   Homing forces dir=0.
//  - Zero move (!cmd_home, cmd_steps==0) -> FINISH; no pulse; dir_o unchanged.
//  - Homing with synced switch already high -> position=0, homed=1, FINISH; no pulse.
//  - dir differs from dir_o -> dir_o updated at N+1, SETUP for DIR_SETUP cycles, then HIGH.
//  - else -> HIGH at N+1: step_o rises at N+1.
//  HIGH: step_o=1 for hp cycles. On entering HIGH, position += 1 (dir=1) or -= 1 (dir=0).
//   position wraps modulo 2^POS_W.
//  LOW: step_o=0 for hp cycles. Step period is exactly 2*hp cycles.
//  At the last LOW cycle:
//   - dir=0 and synced switch=1 (homing or a negative move): position=0, homed=1, FINISH.
//   - else move: remaining-1; remaining==0 -> FINISH, else HIGH.
//   - else homing: HIGH (unbounded until switch).
//  FINISH: done=1 for one cycle -> IDLE (cmd_ready=1 next cycle).
//   Back-to-back commands have no dead cycle beyond FINISH.
//  abort in SETUP/HIGH/LOW: next cycle step_o=0, FINISH. position keeps completed steps;
//   a pulse cut short still counts. abort in IDLE/FINISH is ignored; abort with accept -> accept wins.
//  home_sw passes through SYNC_STAGES flops before use; a switch hit is only sampled at end of LOW.
//  half_period and cmd_* changes while busy have no effect.
//  Async reset mid-pulse: step_o drops immediately; no done is generated.
// STRUCTURE
//  stepper_pkg: state enum (ST_IDLE..ST_FINISH), DIR_POS=1'b1, DIR_NEG=1'b0.
//  Sub-module sync_ff (parameter STAGES, async active-low reset to 0) for home_sw.
//  Everything else is in one FSM with a STEP_W phase counter, STEP_W remaining counter and position register.
// TESTING
//  1 dir_o=1, move steps=3 dir=1 hp=4 -> step_o high at N+1, 3 pulses of 4H/4L, position=3, done at N+25.
//  2 dir_o=1, move steps=2 dir=0 hp=2 DIR_SETUP=16 -> dir_o=0 at N+1, first step at N+17, position=1, one done.
//  3 home, switch rises after 5th pulse (+sync) -> exactly 5 or 6 pulses, position=0, homed=1, done once.
//  4 steps=100 hp=10, abort during pulse 7 -> step_o=0 next cycle, position=+7, done pulse, cmd_ready after.
//  5 steps=0 -> no step_o edge, done at N+1; home with switch high -> no pulse, homed=1, position=0.
//  6 reset_n low mid-pulse -> step_o=0 async, position=0, homed=0; with cmd_valid held, cmd_ready=1 and accept on release.

Source files
------------

// File: rtl/stepper_pkg.sv
// Shared types for the stepper step/dir generator.
// Holds the FSM state encoding and the direction constants.
package stepper_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HIGH,
        ST_LOW,
        ST_FINISH
    } state_e;

    localparam logic DIR_POS = 1'b1;
    localparam logic DIR_NEG = 1'b0;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous input.
// Ports: clock, reset_n (async active-low, clears to 0), d (async in), q (synced out).
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/stepper_step_gen.sv
// Step/dir pulse generator for one stepper axis with homing support.
// Ports: cmd_* handshake in, abort, home_sw; step_o/dir_o pins, busy/done, position, homed.
module stepper_step_gen
    import stepper_pkg::*;
#(
    parameter int STEP_W      = 16,
    parameter int POS_W       = 32,
    parameter int DIR_SETUP   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [STEP_W-1:0]       cmd_steps,
    input  logic                    cmd_dir,
    input  logic                    cmd_home,
    input  logic [STEP_W-1:0]       half_period,
    input  logic                    abort,
    input  logic                    home_sw,
    output logic                    step_o,
    output logic                    dir_o,
    output logic                    busy,
    output logic                    done,
    output logic signed [POS_W-1:0] position,
    output logic                    homed
);

    localparam logic [STEP_W-1:0] ONE_S      = STEP_W'(1);
    localparam logic [STEP_W-1:0] SETUP_LAST = STEP_W'(DIR_SETUP - 1);

    state_e state_q, state_d;
    logic [STEP_W-1:0] phase_q, phase_d;
    logic [STEP_W-1:0] rem_q, rem_d;
    logic [STEP_W-1:0] hp_q, hp_d;
    logic home_q, home_d;
    logic dir_q, dir_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic homed_q, homed_d;

    logic sw_sync;
    logic [STEP_W-1:0] hp_eff;
    logic new_dir;

    sync_ff #(
        .STAGES(SYNC_STAGES)
    ) u_sw_sync (
        .clock  (clock),
        .reset_n(reset_n),
        .d      (home_sw),
        .q      (sw_sync)
    );

    // Sign-extended +1 / -1 increment for the given direction.
    function automatic logic [POS_W-1:0] pos_inc(input logic d);
        pos_inc = {{(POS_W-1){~d}}, 1'b1};
    endfunction

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        rem_d   = rem_q;
        hp_d    = hp_q;
        home_d  = home_q;
        dir_d   = dir_q;
        pos_d   = pos_q;
        homed_d = homed_q;

        hp_eff  = (half_period == '0) ? ONE_S : half_period;
        new_dir = cmd_home ? DIR_NEG : cmd_dir;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    hp_d   = hp_eff;
                    home_d = cmd_home;
                    rem_d  = cmd_steps;
                    if (!cmd_home && cmd_steps == '0) begin
                        state_d = ST_FINISH;
                    end else if (cmd_home && sw_sync) begin
                        pos_d   = '0;
                        homed_d = 1'b1;
                        state_d = ST_FINISH;
                    end else if (new_dir != dir_q) begin
                        dir_d   = new_dir;
                        phase_d = SETUP_LAST;
                        state_d = ST_SETUP;
                    end else begin
                        dir_d   = new_dir;
                        phase_d = hp_eff - ONE_S;
                        pos_d   = pos_q + pos_inc(new_dir);
                        state_d = ST_HIGH;
                    end
                end
            end
            ST_SETUP: begin
                if (abort) begin
                    state_d = ST_FINISH;
                end else if (phase_q == '0) begin
                    phase_d = hp_q - ONE_S;
                    pos_d   = pos_q + pos_inc(dir_q);
                    state_d = ST_HIGH;
                end else begin
                    phase_d = phase_q - ONE_S;
                end
            end
            ST_HIGH: begin
                if (abort) begin
                    state_d = ST_FINISH;
                end else if (phase_q == '0) begin
                    phase_d = hp_q - ONE_S;
                    state_d = ST_LOW;
                end else begin
                    phase_d = phase_q - ONE_S;
                end
            end
            ST_LOW: begin
                if (abort) begin
                    state_d = ST_FINISH;
                end else if (phase_q == '0) begin
                    // Switch is only honoured on the last low cycle of a negative step.
                    if (dir_q == DIR_NEG && sw_sync) begin
                        pos_d   = '0;
                        homed_d = 1'b1;
                        state_d = ST_FINISH;
                    end else if (!home_q && rem_q == ONE_S) begin
                        rem_d   = '0;
                        state_d = ST_FINISH;
                    end else begin
                        if (!home_q) begin
                            rem_d = rem_q - ONE_S;
                        end
                        phase_d = hp_q - ONE_S;
                        pos_d   = pos_q + pos_inc(dir_q);
                        state_d = ST_HIGH;
                    end
                end else begin
                    phase_d = phase_q - ONE_S;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            rem_q   <= '0;
            hp_q    <= ONE_S;
            home_q  <= 1'b0;
            dir_q   <= DIR_NEG;
            pos_q   <= '0;
            homed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            rem_q   <= rem_d;
            hp_q    <= hp_d;
            home_q  <= home_d;
            dir_q   <= dir_d;
            pos_q   <= pos_d;
            homed_q <= homed_d;
        end
    end

    // Outputs decode straight from flops so reset clears step_o immediately.
    assign step_o    = (state_q == ST_HIGH);
    assign done      = (state_q == ST_FINISH);
    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = ~cmd_ready;
    assign dir_o     = dir_q;
    assign position  = pos_q;
    assign homed     = homed_q;

endmodule
